// File: rtl/if_id_queue_pkg.sv
// if_id_queue_pkg: shared CPU pipeline constants used by the fetch/decode queue
package if_id_queue_pkg;
  localparam logic [31:0] INST_NOP = 32'h0000_0000;
  localparam int IFQ_DEPTH = 4;
  localparam int PC_INC = 4;
endpackage

// File: rtl/if_queue_ram.sv
// if_queue_ram: DEPTH-entry {pc, inst} storage, one write port, asynchronous read port
module if_queue_ram #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/if_id_queue.sv
// if_id_queue: circular fetch-to-decode buffer with single-cycle flush on redirect
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int WIDTH = 32
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_pc,
  input  logic [WIDTH-1:0]       in_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_pc,
  output logic [WIDTH-1:0]       out_inst,
  output logic [WIDTH-1:0]       out_pc4,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [2*WIDTH-1:0] rdata;
  logic empty, full, push, pop;
  always_comb begin
    empty = wr_ptr == rd_ptr;
    full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    in_ready = !full && !Rst;
    out_valid = !empty;
    push = in_valid && in_ready && !flush;
    pop = out_valid && out_ready;
    count = wr_ptr - rd_ptr;
    out_pc = empty ? '0 : rdata[2*WIDTH-1:WIDTH];
    out_inst = empty ? WIDTH'(INST_NOP) : rdata[WIDTH-1:0];
    out_pc4 = out_pc + WIDTH'(PC_INC);
  end
  always_ff @(posedge Clk)
    if (Rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  if_queue_ram #(.DEPTH(DEPTH), .W(2*WIDTH)) u_ram (
    .clk  (Clk),
    .we   (push),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({in_pc, in_inst}),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed stimulus with scoreboard queue and decoupled negedge monitor
module tb_if_id_queue;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  logic Clk = 0, Rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] in_pc = 0, in_inst = 0, out_pc, out_inst, out_pc4;
  logic [2:0] count;
  ent_t exp_q[$];
  ent_t e;
  int n_cmp = 0, n_bad = 0;
  logic chk_en = 0, chk_end = 0;
  string chk_name = "";
  int x_cnt;
  logic x_ov, x_ir;
  logic [31:0] x_pc, x_inst, x_pc4;

  if_id_queue #(.DEPTH(4), .WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_pc4(out_pc4), .count(count)
  );

  always #5 Clk = ~Clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  always @(negedge Clk) begin
    if (out_valid && out_ready && !flush && !Rst) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pop_unexpected: got pc %h, required no entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        cmp("pop_pc", out_pc, e.pc);
        cmp("pop_inst", out_inst, e.inst);
      end
    end
    if (chk_en) begin
      cmp({chk_name, "_count"}, 32'(count), x_cnt);
      cmp({chk_name, "_out_valid"}, 32'(out_valid), 32'(x_ov));
      cmp({chk_name, "_in_ready"}, 32'(in_ready), 32'(x_ir));
      cmp({chk_name, "_out_pc"}, out_pc, x_pc);
      cmp({chk_name, "_out_inst"}, out_inst, x_inst);
      cmp({chk_name, "_out_pc4"}, out_pc4, x_pc4);
    end
    if (chk_end) cmp("leftover_entries", 32'(exp_q.size()), 0);
  end

  task automatic drive(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc = pc;
    in_inst = 32'hA500_0000 | pc;
  endtask

  task automatic expect_st(input string nm, input int c, input logic ov, input logic ir,
                           input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] pc4);
    chk_name = nm;
    x_cnt = c;
    x_ov = ov;
    x_ir = ir;
    x_pc = pc;
    x_inst = inst;
    x_pc4 = pc4;
    chk_en = 1;
  endtask

  task automatic step;
    logic acc;
    @(negedge Clk);
    acc = in_valid && in_ready && !flush && !Rst;
    @(posedge Clk);
    #1;
    chk_en = 0;
    chk_end = 0;
    if (flush || Rst) exp_q.delete();
    else if (acc) exp_q.push_back('{in_pc, in_inst});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    step;
    expect_st("in_reset", 0, 0, 0, 32'h0, 32'h0, 32'h4);
    step;
    Rst = 0;
    expect_st("post_reset", 0, 0, 1, 32'h0, 32'h0, 32'h4);
    step;
    drive(1, 32'h00); step;
    drive(1, 32'h04); step;
    drive(1, 32'h08); step;
    drive(0, 32'h0);
    expect_st("three", 3, 1, 1, 32'h00, 32'hA500_0000, 32'h04);
    step;
    out_ready = 1;
    repeat (3) step;
    out_ready = 0;
    drive(1, 32'h00);
    expect_st("drained", 0, 0, 1, 32'h0, 32'h0, 32'h4);
    step;
    drive(1, 32'h04); step;
    drive(1, 32'h08); step;
    drive(1, 32'h0C); step;
    drive(1, 32'h10);
    expect_st("full", 4, 1, 0, 32'h00, 32'hA500_0000, 32'h04);
    step;
    out_ready = 1;
    step;
    out_ready = 0;
    expect_st("after_pop", 3, 1, 1, 32'h04, 32'hA500_0004, 32'h08);
    step;
    drive(0, 32'h0);
    expect_st("refill", 4, 1, 0, 32'h04, 32'hA500_0004, 32'h08);
    out_ready = 1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) step;
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'(i * 4));
      if (i > 0) expect_st("stream", 1, 1, 1, 32'((i - 1) * 4), 32'hA500_0000 | 32'((i - 1) * 4), 32'(i * 4));
      step;
    end
    drive(0, 32'h0);
    step;
    out_ready = 0;
    drive(1, 32'h00); step;
    drive(1, 32'h04); step;
    drive(1, 32'h08); step;
    drive(1, 32'h20);
    flush = 1;
    expect_st("flush_cycle", 3, 1, 1, 32'h00, 32'hA500_0000, 32'h04);
    step;
    flush = 0;
    drive(0, 32'h0);
    expect_st("after_flush", 0, 0, 1, 32'h0, 32'h0, 32'h4);
    step;
    out_ready = 1;
    repeat (3) step;
    out_ready = 0;
    drive(1, 32'h40); step;
    drive(1, 32'h44); step;
    drive(0, 32'h0);
    Rst = 1;
    expect_st("reset_cycle", 2, 1, 0, 32'h40, 32'hA500_0040, 32'h44);
    step;
    Rst = 0;
    drive(1, 32'h48);
    expect_st("after_reset", 0, 0, 1, 32'h0, 32'h0, 32'h4);
    step;
    drive(0, 32'h0);
    expect_st("first_push", 1, 1, 1, 32'h48, 32'hA500_0048, 32'h4C);
    out_ready = 1;
    step;
    out_ready = 0;
    drive(1, 32'hFFFF_FFFC);
    step;
    drive(0, 32'h0);
    expect_st("pc4_wrap", 1, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000);
    out_ready = 1;
    step;
    out_ready = 0;
    expect_st("final", 0, 0, 1, 32'h0, 32'h0, 32'h4);
    chk_end = 1;
    step;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Decoupling buffer between the instruction fetch stage and the decode stage of the CPU pipeline. It captures each fetched `{pc, instruction}` pair into a small circular queue and presents the oldest entry to decode. Fetch can therefore run ahead while decode stalls. A redirect (branch, jump, exception or `eret`, meaning any non-sequential PC select) discards every queued instruction in one cycle.

## Interface
Parameters:
- `DEPTH`, default 4: number of entries. Must be a power of two and at least 2.
- `WIDTH`, default 32: width of the PC and instruction fields.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Rst`  in  1  synchronous reset, active-high.
- `flush`  in  1  redirect pulse; empties the queue.
- `in_valid`  in  1  fetch presents a valid entry.
- `in_ready`  out  1  queue can accept an entry this cycle.
- `in_pc`  in  WIDTH  PC of the fetched instruction.
- `in_inst`  in  WIDTH  fetched instruction word.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  decode consumes the head this cycle.
- `out_pc`  out  WIDTH  PC of the head entry.
- `out_inst`  out  WIDTH  instruction of the head entry; NOP (`32'h0000_0000`) when the queue is empty.
- `out_pc4`  out  WIDTH  `out_pc + 4`, truncated to WIDTH; wraps silently.
- `count`  out  log2(DEPTH)+1  current occupancy, from 0 to DEPTH.

## Operation
- Storage is a DEPTH-entry array of `{pc, inst}`.
- `wr_ptr` and `rd_ptr` are log2(DEPTH)+1 bits wide. The MSB is a wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- A push occurs when `in_valid && in_ready`:
  - write at `wr_ptr`;
  - increment `wr_ptr`.
- A pop occurs when `out_valid && out_ready`:
  - increment `rd_ptr`.
- `in_ready = !full && !Rst`. It does not depend on `out_ready`, so a full queue rejects a push even if a pop occurs in the same cycle.
- `out_valid = !empty`. There is no input-to-output bypass.
- Simultaneous push and pop when neither full nor empty: both happen and `count` is unchanged.
- Pointer wrap: increments are modulo 2·DEPTH. An index of DEPTH-1 wraps to 0 and toggles the wrap bit.
- `flush`:
  - at the next edge, both pointers are set to 0 and `count` to 0;
  - a push or pop in the flush cycle is ignored;
  - flush takes priority over push and pop.
- `Rst` has the same effect as `flush`. Array contents are not cleared.
- Empty queue: `out_pc` = 0, `out_inst` = NOP, `out_pc4` = 4.
- `in_pc` is passed through unmodified. No alignment checks are made.

## Timing
- Reset values:
  - `in_ready` = 0 while `Rst` is high, 1 in the first cycle after;
  - `out_valid` = 0, `count` = 0, `out_pc` = 0, `out_inst` = 0, `out_pc4` = 4.
- Latency:
  - a push at edge N gives `out_valid` = 1 with that entry in the cycle after edge N;
  - minimum fetch-to-decode latency is 1 cycle.
- Throughput: one push and one pop per cycle in steady state.
- `in_ready`, `out_valid` and the `out_*` data are derived from registered state only. There are no combinational paths from `out_ready` or `in_valid`.
- Flush asserted in cycle N gives `out_valid` = 0 and `in_ready` = 1 in cycle N+1.
- Fetch must hold `in_pc` and `in_inst` stable while `in_valid && !in_ready`. Decode must not rely on the `out_*` data when `out_valid` = 0.

## Structure
- Shared CPU package holds:
  - `INST_NOP` = 32'h0000_0000;
  - the default `IFQ_DEPTH` = 4;
  - the PC increment constant 4, the same constant the fetch adder uses.
- One natural sub-module is `if_queue_ram`: the DEPTH×(2·WIDTH) register array with one write port and one asynchronous read port.
- Pointer, flag and flush logic stays in the top module.

## Test plan
- Reset, then push PCs 0x00, 0x04, 0x08 with `out_ready` = 0 → `count` = 3; `out_pc` = 0x00, `out_pc4` = 0x04.
- Push five entries with `out_ready` = 0 and DEPTH = 4 → `in_ready` = 0 after the 4th push; the 5th is held by fetch and accepted after one pop; order is preserved (0x00, 0x04, 0x08, 0x0C, 0x10).
- Continuous push and pop for 20 cycles, crossing the pointer wrap → `count` stays at 1 and the output PC sequence is contiguous from 0x00 with step 4.
- `flush` in the same cycle as a push of 0x20 with three entries queued → next cycle `count` = 0, `out_valid` = 0, `out_inst` = NOP; 0x20 never appears.
- `Rst` asserted mid-stream with two entries queued → next cycle all outputs are at reset values; the first push after reset appears 1 cycle later.
- Empty queue with `in_pc` = 0xFFFF_FFFC pushed → `out_pc4` = 0x0000_0000 (wrap).
